// File: rtl/parity_check_rx.sv
// Odd-parity checker with a small payload FIFO and a saturating error counter.
// Define PARITY_ERR_FORWARD_EN to store failing words, tagged, instead of dropping them.
module parity_check_rx #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [8:0]       out_data,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_pulse
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

`ifdef PARITY_ERR_FORWARD_EN
  localparam int unsigned EW = 10;
`else
  localparam int unsigned EW = 9;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          good, push, pop, wr_en;
  logic [EW-1:0] entry;

  assign good      = ^in_word;
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr][8:0];

`ifdef PARITY_ERR_FORWARD_EN
  assign wr_en   = push;
  assign entry   = {~good, in_word[9:1]};
  // Gate with out_valid so unwritten storage never leaks onto out_err.
  assign out_err = out_valid && mem[rd_ptr][9];
`else
  assign wr_en   = push && good;
  assign entry   = in_word[9:1];
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !pop) begin
        count <= count + 1'b1;
      end else if (!wr_en && pop) begin
        count <= count - 1'b1;
      end
      // Clear wins over a same-cycle increment; the pulse still reports the error.
      if (err_clr) begin
        err_cnt <= '0;
      end else if (push && !good && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
      err_pulse <= push && !good;
    end
  end

endmodule

// File: tb/tb_parity_check_rx.sv
// Directed self-checking bench for parity_check_rx (DEPTH=4, CNT_W=2).
module tb_parity_check_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] in_word;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] out_data;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;
  logic       err_clr;
  logic [1:0] err_cnt;
  logic       err_pulse;

  int n_checks = 0;
  int n_errs   = 0;

  logic [8:0] exp_q[$];
  logic [8:0] vals[8];

  parity_check_rx #(
    .DEPTH(4),
    .CNT_W(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_word  (in_word),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_err  (out_err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_clr  (err_clr),
    .err_cnt  (err_cnt),
    .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] enc(input logic [8:0] d);
    return {d, ~^d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle against the queue model of good payloads held in the FIFO.
  task automatic tick_check(output bit accepted);
    bit popped;
    check("fifo_in_ready", in_ready, exp_q.size() != 4);
    check("fifo_out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("fifo_out_data", out_data, exp_q[0]);
    accepted = in_valid && (exp_q.size() != 4);
    popped   = out_ready && (exp_q.size() != 0);
    step();
    if (popped) void'(exp_q.pop_front());
    if (accepted) exp_q.push_back(in_word[9:1]);
  endtask

  initial begin
    bit acc;
    int idx;
    reset = 1'b1; in_word = '0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    check("rst_err_cnt", err_cnt, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_err", out_err, 0);

    // Good words with consumer ready
    out_ready = 1'b1;
    in_word = 10'h14B; in_valid = 1'b1;
    step();
    in_word = 10'h3FE;
    check("good1_valid", out_valid, 1);
    check("good1_data", out_data, 9'h0A5);
    check("good1_err", out_err, 0);
    step();
    in_valid = 1'b0;
    check("good2_valid", out_valid, 1);
    check("good2_data", out_data, 9'h1FF);
    step();
    check("good_drained", out_valid, 0);
    check("good_err_cnt", err_cnt, 0);
    check("good_no_pulse", err_pulse, 0);

    // Single bad word, consumer stalled
    out_ready = 1'b0;
    in_word = 10'h14A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("bad_pulse", err_pulse, 1);
    check("bad_err_cnt", err_cnt, 1);
`ifdef PARITY_ERR_FORWARD_EN
    check("bad_fwd_valid", out_valid, 1);
    check("bad_fwd_data", out_data, 9'h0A5);
    check("bad_fwd_err", out_err, 1);
`else
    check("bad_dropped", out_valid, 0);
    check("bad_out_err", out_err, 0);
`endif
    step();
    check("bad_pulse_once", err_pulse, 0);
    out_ready = 1'b1; err_clr = 1'b1;
    step();
    out_ready = 1'b0; err_clr = 1'b0;
    check("clr_err_cnt", err_cnt, 0);
    check("clr_empty", out_valid, 0);

    // Fill, backpressure, then stream across pointer wrap
    for (int i = 0; i < 8; i++) vals[i] = 9'(9'h023 * (i + 1));
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_word = enc(vals[idx]); in_valid = 1'b1;
      tick_check(acc);
      if (acc) idx++;
    end
    check("full_accepted", idx, 4);
    check("full_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 30 && (idx < 8 || exp_q.size() != 0); c++) begin
      in_valid = (idx < 8);
      if (idx < 8) in_word = enc(vals[idx]);
      tick_check(acc);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("stream_all_pushed", idx, 8);
    check("stream_model_empty", exp_q.size(), 0);
    check("stream_drained", out_valid, 0);

    // Saturating counter with CNT_W=2
    in_word = 10'h14A; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("sat_err_cnt", err_cnt, (i < 3) ? i + 1 : 3);
      check("sat_pulse", err_pulse, 1);
    end
    err_clr = 1'b1;
    step();
    check("clr_vs_inc_cnt", err_cnt, 0);
    check("clr_vs_inc_pulse", err_pulse, 1);
    err_clr = 1'b0; in_valid = 1'b0;
    step();
    check("sat_pulse_end", err_pulse, 0);
    for (int c = 0; c < 6; c++) step();
    check("sat_drained", out_valid, 0);

    // Async reset with entries held
    out_ready = 1'b0;
    in_word = 10'h14A; in_valid = 1'b1;
    step();
    in_word = enc(9'h011); step();
    in_word = enc(9'h022); step();
    in_word = enc(9'h033); step();
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_err_cnt", err_cnt, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_err_cnt", err_cnt, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_err", out_err, 0);
    #3 reset = 1'b0;
    step();
    in_word = 10'h3FE; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("post_rst_valid", out_valid, 1);
    check("post_rst_data", out_data, 9'h1FF);
    out_ready = 1'b1;
    step();
    check("post_rst_only_new", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
